// File: rtl/pattern_det_ctrl_if.sv
// Host-side bundle for the pattern detector run controller: configuration,
// run control, gated serial input and match/status outputs.
interface pattern_det_ctrl_if #(
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned LEN_W = $clog2(PAT_MAX + 1);

  logic               cfg_we;
  logic [PAT_MAX-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               abort;
  logic               in;
  logic               in_valid;
  logic               out;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   match_cnt;

  // Host / sequencer side
  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, in, in_valid,
    input  out, busy, done, match_cnt
  );

  // Detector side
  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, in, in_valid,
    output out, busy, done, match_cnt
  );
endinterface

// File: rtl/pattern_det_ctrl.sv
// Run controller for the serial sequence detector: programmable pattern,
// length and overlap mode, match counting against a target, busy/done status.
// Optional macro MATCH_REG_EN: when defined, the match pulse is registered
// (one cycle after the matching bit); otherwise it is a Mealy pulse.
module pattern_det_ctrl #(
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned CNT_W   = 8
) (
  input logic               clk,
  input logic               R,
  pattern_det_ctrl_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(PAT_MAX + 1);
  localparam int unsigned HW    = PAT_MAX - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [PAT_MAX-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic [CNT_W-1:0]   target;
  logic [HW-1:0]      history;
  logic [LEN_W-1:0]   fill;
  logic [CNT_W-1:0]   match_cnt_q;
  logic               busy_q;
  logic               done_q;

  logic [PAT_MAX-1:0] window;
  logic [PAT_MAX-1:0] mask;
  logic [LEN_W-1:0]   cfg_len_eff;
  logic [LEN_W-1:0]   fill_inc;
  logic [CNT_W-1:0]   cnt_inc;
  logic               match_c;
  logic               target_hit_c;

  // Newest bit joins the stored history; only the low len bits are compared
  assign window = {history, bus.in};

  // Length mask and clamped config length (0 -> 1, above PAT_MAX -> PAT_MAX)
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    cfg_len_eff = bus.cfg_len;
    if (bus.cfg_len == '0) begin
      cfg_len_eff = LEN_W'(1);
    end else if (bus.cfg_len > LEN_W'(PAT_MAX)) begin
      cfg_len_eff = LEN_W'(PAT_MAX);
    end
  end

  // Mealy match decode and saturating increments
  always_comb begin
    match_c      = (state == RUN) && bus.in_valid &&
                   (fill >= (len - LEN_W'(1))) &&
                   ((window & mask) == (pattern & mask));
    target_hit_c = (target != '0) && ((match_cnt_q + CNT_W'(1)) == target);
    fill_inc     = (fill == LEN_W'(PAT_MAX)) ? fill : fill + LEN_W'(1);
    cnt_inc      = (&match_cnt_q) ? match_cnt_q : match_cnt_q + CNT_W'(1);
  end

  // Run-control FSM with configuration, history and counter registers
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state       <= IDLE;
      pattern     <= PAT_MAX'(3'b101);
      len         <= LEN_W'(3);
      overlap     <= 1'b0;
      target      <= '0;
      history     <= '0;
      fill        <= '0;
      match_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.in_valid) begin
            if (match_c && !overlap) begin
              history <= '0;
              fill    <= '0;
            end else begin
              history <= window[HW-1:0];
              fill    <= fill_inc;
            end
          end
          if (match_c) begin
            match_cnt_q <= cnt_inc;
          end
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end else if (match_c && target_hit_c) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        IDLE, DONE: begin
          if (bus.cfg_we) begin
            pattern <= bus.cfg_pattern;
            len     <= cfg_len_eff;
            overlap <= bus.cfg_overlap;
            target  <= bus.cfg_target;
          end
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end else if (bus.start) begin
            state       <= RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            history     <= '0;
            fill        <= '0;
            match_cnt_q <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef MATCH_REG_EN
  logic out_q;

  // One-cycle registered copy of the match pulse
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      out_q <= 1'b0;
    end else begin
      out_q <= match_c;
    end
  end

  assign bus.out = out_q;
`else
  assign bus.out = match_c;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.match_cnt = match_cnt_q;
endmodule
